// File: rtl/iec_sd_arbiter_pkg.sv
// Shared types and helpers for the drive-side block-device arbiters.
package iec_drive_pkg;

  localparam int MAX_DRIVES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } sd_arb_state_t;

  function automatic int clamp_drives(input int drives);
    if (drives < 1) return 1;
    if (drives > MAX_DRIVES) return MAX_DRIVES;
    return drives;
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// Host block-device port: request, address, ack and buffer bus.
interface iec_sd_arbiter_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Round-robin picker: first pending requester after rr, wrapping at NDR.
module rr_pick
  import iec_drive_pkg::*;
#(
  parameter int NDR = 2
) (
  input  logic [NDR-1:0] pend,
  input  logic [1:0]     rr,
  output logic [1:0]     idx,
  output logic           valid
);

  logic [MAX_DRIVES-1:0] pend_ext;
  logic [1:0]            cand;

  always_comb begin
    pend_ext          = '0;
    pend_ext[NDR-1:0] = pend;
  end

  // cand walks rr+1, rr+2, ... modulo NDR; the first hit wins
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    cand  = rr;
    for (int i = 0; i < NDR; i++) begin
      cand = (cand == 2'(NDR - 1)) ? 2'd0 : cand + 2'd1;
      if (!valid && pend_ext[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Shares one host block-device channel between up to four drives,
// one transaction at a time, with per-request ack timeout.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches lba/blk_cnt/op
// ISSUE | sd_rd/sd_wr asserted, waiting for sd_ack rise (or cancel/timeout)
// XFER  | ack and buffer bus steered to the granted drive until sd_ack falls
// DONE  | one gap cycle; round-robin pointer advanced, counter cleared
module iec_sd_arbiter
  import iec_drive_pkg::*;
#(
  parameter int          DRIVES  = 2,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000,
  localparam int         NDR     = clamp_drives(DRIVES)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NDR-1:0][31:0] drv_lba,
  input  logic [NDR-1:0][5:0]  drv_blk_cnt,
  input  logic [NDR-1:0]       drv_rd,
  input  logic [NDR-1:0]       drv_wr,
  output logic [NDR-1:0]       drv_ack,
  input  logic [NDR-1:0][7:0]  drv_buff_din,
  output logic [NDR-1:0]       drv_buff_wr,
  output logic [NDR-1:0]       drv_err,
  iec_sd_arbiter_if.master     sd,
  output logic                 busy,
  output logic [1:0]           grant
);

  sd_arb_state_t state, state_nx;

  logic [1:0]      rr;
  logic            op_rd;
  logic [23:0]     cnt;
  logic [NDR-1:0]  err_q;
  logic [31:0]     lba_q;
  logic [5:0]      blk_q;

  logic [NDR-1:0]  pend;
  logic [NDR-1:0]  grant_oh;
  logic [1:0]      pick_idx;
  logic            pick_valid;
  logic            start;
  logic            cancel;
  logic            timed_out;

  logic [MAX_DRIVES-1:0][31:0] lba_ext;
  logic [MAX_DRIVES-1:0][5:0]  blk_ext;
  logic [MAX_DRIVES-1:0][7:0]  din_ext;
  logic [MAX_DRIVES-1:0]       rd_ext;

  // Widen the per-drive buses to MAX_DRIVES so a 2-bit grant indexes them cleanly
  for (genvar g = 0; g < MAX_DRIVES; g++) begin : g_ext
    if (g < NDR) begin : g_on
      assign lba_ext[g] = drv_lba[g];
      assign blk_ext[g] = drv_blk_cnt[g];
      assign din_ext[g] = drv_buff_din[g];
      assign rd_ext[g]  = drv_rd[g];
    end else begin : g_off
      assign lba_ext[g] = '0;
      assign blk_ext[g] = '0;
      assign din_ext[g] = '0;
      assign rd_ext[g]  = 1'b0;
    end
  end

  assign pend     = drv_rd | drv_wr;
  assign grant_oh = NDR'(1) << grant;

  rr_pick #(.NDR(NDR)) u_pick (
    .pend  (pend),
    .rr    (rr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // A stale ack still high from the host blocks the next grant
  assign start     = pick_valid && !sd.sd_ack;
  assign cancel    = ~|(pend & grant_oh);
  assign timed_out = (TIMEOUT != 24'd0) && (cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE: begin
        if (sd.sd_ack)                state_nx = XFER;
        else if (cancel || timed_out) state_nx = DONE;
      end
      XFER:    if (!sd.sd_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant <= 2'd0;
      rr    <= 2'd0;
      op_rd <= 1'b0;
      cnt   <= 24'd0;
      err_q <= '0;
      lba_q <= 32'd0;
      blk_q <= 6'd0;
    end else begin
      err_q <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            grant <= pick_idx;
            lba_q <= lba_ext[pick_idx];
            blk_q <= blk_ext[pick_idx];
            op_rd <= rd_ext[pick_idx];
          end
        end
        ISSUE: begin
          cnt <= cnt + 24'd1;
          if (!sd.sd_ack && !cancel && timed_out) err_q <= grant_oh;
        end
        DONE: begin
          rr  <= grant;
          cnt <= 24'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sd.sd_rd    = 1'b0;
    sd.sd_wr    = 1'b0;
    drv_ack     = '0;
    drv_buff_wr = '0;
    case (state)
      ISSUE: begin
        sd.sd_rd = op_rd;
        sd.sd_wr = ~op_rd;
      end
      XFER: begin
        drv_ack     = sd.sd_ack     ? grant_oh : '0;
        drv_buff_wr = sd.sd_buff_wr ? grant_oh : '0;
      end
      default: ;
    endcase
  end

  assign busy           = (state != IDLE);
  assign drv_err        = err_q;
  assign sd.sd_lba      = lba_q;
  assign sd.sd_blk_cnt  = blk_q;
  assign sd.sd_buff_din = din_ext[grant];

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Bench for iec_sd_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_iec_sd_arbiter;

  localparam int          ND = 4;
  localparam logic [23:0] TO = 24'd16;

  logic                 clk_sys = 1'b0;
  logic                 reset   = 1'b1;
  logic [ND-1:0][31:0]  drv_lba      = '0;
  logic [ND-1:0][5:0]   drv_blk_cnt  = '0;
  logic [ND-1:0][7:0]   drv_buff_din = '0;
  logic [ND-1:0]        drv_rd = '0;
  logic [ND-1:0]        drv_wr = '0;
  logic [ND-1:0]        drv_ack, drv_buff_wr, drv_err;
  logic                 busy;
  logic [1:0]           grant;

  int tests = 0;
  int fails = 0;
  int m_rr  = 0;
  int hi;

  iec_sd_arbiter_if sd();

  iec_sd_arbiter #(.DRIVES(ND), .TIMEOUT(TO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .drv_err      (drv_err),
    .sd           (sd),
    .busy         (busy),
    .grant        (grant)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending drive after the last one served
  function automatic int exp_pick(input logic [ND-1:0] p, input int last);
    logic [1:0] d;
    for (int k = 1; k <= ND; k++) begin
      d = 2'(last + k);
      if (p[d]) return int'(d);
    end
    return -1;
  endfunction

  // Entered just after an edge with the DUT idle and requests already applied
  task automatic txn(input int ack_dly, input int xlen);
    int            g;
    logic [ND-1:0] oh;
    logic          rdop;
    logic          bw;
    g = exp_pick(drv_rd | drv_wr, m_rr);
    chk("pick_valid", 64'(g >= 0), 64'd1);
    if (g < 0) return;
    oh   = 4'b0001 << g;
    rdop = drv_rd[g];
    tick();
    chk("grant",       64'(grant), 64'(g));
    chk("issue_busy",  64'(busy), 64'd1);
    chk("issue_lba",   64'(sd.sd_lba), 64'(drv_lba[g]));
    chk("issue_blk",   64'(sd.sd_blk_cnt), 64'(drv_blk_cnt[g]));
    chk("issue_op",    64'({sd.sd_rd, sd.sd_wr}), 64'({rdop, !rdop}));
    chk("issue_din",   64'(sd.sd_buff_din), 64'(drv_buff_din[g]));
    chk("issue_noack", 64'(drv_ack), 64'd0);
    for (int i = 1; i < ack_dly; i++) tick();
    chk("issue_hold", 64'({sd.sd_rd, sd.sd_wr}), 64'({rdop, !rdop}));
    sd.sd_ack = 1'b1;
    tick();
    chk("xfer_req_drop", 64'({sd.sd_rd, sd.sd_wr}), 64'd0);
    chk("xfer_ack",      64'(drv_ack), 64'(oh));
    drv_rd[g] = 1'b0;
    drv_wr[g] = 1'b0;
    drv_rd    = drv_rd | (4'($urandom_range(0, 15)) & ~oh);
    for (int i = 0; i < xlen; i++) begin
      bw = 1'($urandom_range(0, 1));
      sd.sd_buff_wr = bw;
      #1;
      chk("xfer_bwr",      64'(drv_buff_wr), bw ? 64'(oh) : 64'd0);
      chk("xfer_din",      64'(sd.sd_buff_din), 64'(drv_buff_din[g]));
      chk("xfer_ack_hold", 64'(drv_ack), 64'(oh));
      tick();
    end
    sd.sd_ack     = 1'b0;
    sd.sd_buff_wr = 1'b0;
    #1;
    chk("ack_fall", 64'(drv_ack), 64'd0);
    tick();
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_err",  64'(drv_err), 64'd0);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    m_rr = g;
  endtask

  initial begin
    sd.sd_ack     = 1'b0;
    sd.sd_buff_wr = 1'b0;
    tick();
    tick();
    chk("reset_outputs",
        64'({busy, grant, sd.sd_rd, sd.sd_wr, sd.sd_lba, sd.sd_blk_cnt, drv_ack, drv_err, drv_buff_wr}),
        64'd0);
    reset = 1'b0;

    // single read on drive 0, long transfer
    drv_lba[0]     = 32'h123;
    drv_blk_cnt[0] = 6'd0;
    drv_rd         = 4'b0001;
    txn(5, 512);

    // round robin with everyone pending
    drv_rd = 4'b1111;
    drv_wr = 4'b0000;
    for (int i = 0; i < 4; i++) txn(2, 3);

    // write steering on drive 1
    drv_rd = '0;
    drv_wr = 4'b0010;
    drv_buff_din[0] = 8'h5A;
    drv_buff_din[1] = 8'hA5;
    txn(3, 10);

    // timeout on drive 2, drive 3 queued behind it
    drv_rd = 4'b0100;
    drv_wr = '0;
    tick();
    chk("to_grant", 64'(grant), 64'd2);
    drv_rd[3] = 1'b1;
    hi = 0;
    for (int i = 0; i < 40 && sd.sd_rd; i++) begin
      hi++;
      tick();
    end
    chk("to_len", 64'(hi), 64'(TO));
    chk("to_err", 64'(drv_err), 64'b0100);
    drv_rd[2] = 1'b0;
    tick();
    chk("to_err_pulse", 64'(drv_err), 64'd0);
    chk("to_idle",      64'(busy), 64'd0);
    m_rr = 2;
    txn(3, 4);

    // cancel during ISSUE
    drv_rd = '0;
    drv_wr = 4'b0010;
    tick();
    chk("cancel_issue", 64'({grant, sd.sd_rd, sd.sd_wr}), 64'b0101);
    tick();
    drv_wr = '0;
    tick();
    chk("cancel_drop",  64'({busy, sd.sd_rd, sd.sd_wr}), 64'b100);
    chk("cancel_noerr", 64'(drv_err), 64'd0);
    tick();
    chk("cancel_idle",  64'(busy), 64'd0);
    m_rr = 1;

    // reset in the middle of a transfer
    drv_rd = 4'b0001;
    tick();
    sd.sd_ack = 1'b1;
    tick();
    chk("rst_xfer_ack", 64'(drv_ack), 64'b0001);
    reset = 1'b1;
    #1;
    chk("rst_ack_same", 64'(drv_ack), 64'b0001);
    tick();
    chk("rst_outputs",
        64'({busy, grant, sd.sd_rd, sd.sd_wr, sd.sd_lba, sd.sd_blk_cnt, drv_ack, drv_err, drv_buff_wr}),
        64'd0);
    reset     = 1'b0;
    sd.sd_ack = 1'b0;
    drv_rd    = 4'b0011;
    m_rr      = 0;
    txn(2, 3);

    // stray ack while idle, then rd+wr together on one drive
    drv_rd        = '0;
    drv_wr        = '0;
    sd.sd_ack     = 1'b1;
    sd.sd_buff_wr = 1'b1;
    #1;
    chk("stray_ack", 64'({drv_ack, drv_buff_wr}), 64'd0);
    drv_rd[2] = 1'b1;
    drv_wr[2] = 1'b1;
    tick();
    chk("stray_nogrant", 64'({busy, drv_ack}), 64'd0);
    sd.sd_ack     = 1'b0;
    sd.sd_buff_wr = 1'b0;
    txn(4, 6);

    // randomized transactions
    for (int it = 0; it < 24; it++) begin
      for (int d = 0; d < ND; d++) begin
        drv_lba[d]      = $urandom;
        drv_blk_cnt[d]  = 6'($urandom);
        drv_buff_din[d] = 8'($urandom);
        if (!(drv_rd[d] | drv_wr[d])) begin
          drv_rd[d] = 1'($urandom_range(0, 1));
          drv_wr[d] = 1'($urandom_range(0, 1));
        end
      end
      if ((drv_rd | drv_wr) == '0) drv_rd[2'($urandom_range(0, 3))] = 1'b1;
      txn(int'($urandom_range(1, 10)), int'($urandom_range(1, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
